// File: rtl/branch_sequencer_pkg.sv
// Shared types and defaults for the branch fetch/execute sequencer.
package branch_sequencer_pkg;

  localparam logic [4:0]  BR_OPCODE_DEF   = 5'b10010;
  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned TIMER_W         = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_ILL,
    S_MERR
  } state_e;

endpackage

// File: rtl/branch_mem_timer.sv
// Saturating wait counter for the memory-read state; expired flags the last allowed wait cycle.
module branch_mem_timer
  import branch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TIMER_W'(1);
    end
  end

  // count holds completed wait cycles, so the current cycle is number count+1
  assign expired = (count >= (limit - TIMER_W'(1)));

endmodule

// File: rtl/branch_sequencer.sv
// Fetch plus conditional-branch execute control sequencer with memory timeout.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter logic [4:0]  BR_OPCODE   = BR_OPCODE_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic       con_out,
  input  logic       mem_done,
  output logic       pc_out,
  output logic       mar_in,
  output logic       inc_pc,
  output logic       z_in,
  output logic       z_lo_out,
  output logic       pc_in,
  output logic       read,
  output logic       mdr_in,
  output logic       mdr_out,
  output logic       ir_in,
  output logic       gra,
  output logic       r_out,
  output logic       con_in,
  output logic       y_in,
  output logic       c_out,
  output logic       alu_add,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       mem_err
);

  state_e state_q, state_d;
  logic   tmr_clr, tmr_en, tmr_expired;

  branch_mem_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (TIMER_W'(MEM_TIMEOUT)),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Strobes decode from state; T3 strobes gate on a legal opcode, T6 pc_in follows con_out
  always_comb begin
    state_d  = state_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    z_in     = 1'b0;
    z_lo_out = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    busy     = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T0;
      end
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        tmr_clr = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        z_lo_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        tmr_en   = 1'b1;
        if (mem_done)         state_d = S_T2;
        else if (tmr_expired) state_d = S_MERR;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (opcode == BR_OPCODE) begin
          gra     = 1'b1;
          r_out   = 1'b1;
          con_in  = 1'b1;
          state_d = S_T4;
        end else begin
          state_d = S_ILL;
        end
      end
      S_T4: begin
        pc_out  = 1'b1;
        y_in    = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
        state_d = S_T6;
      end
      S_T6: begin
        z_lo_out = 1'b1;
        pc_in    = con_out;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_ILL: begin
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      S_MERR: begin
        mem_err = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized self-checking bench: per-transaction expected output trace built from the sequence rules.
module tb_branch_sequencer;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] opcode = 5'b0;
  logic       con_out = 1'b0;
  logic       mem_done = 1'b0;
  logic pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, read, mdr_in, mdr_out, ir_in;
  logic gra, r_out, con_in, y_in, c_out, alu_add, busy, done, illegal, mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] exp_q[$];
  int          md_q[$];

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .con_out(con_out),
    .mem_done(mem_done), .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .z_lo_out(z_lo_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .gra(gra), .r_out(r_out), .con_in(con_in), .y_in(y_in), .c_out(c_out),
    .alu_add(alu_add), .busy(busy), .done(done), .illegal(illegal), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] obs();
    return {pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, read, mdr_in, mdr_out, ir_in,
            gra, r_out, con_in, y_in, c_out, alu_add, busy, done, illegal, mem_err};
  endfunction

  function automatic logic [19:0] b(input int n);
    return 20'(1) << n;
  endfunction

  // Expected trace: T0, d (capped) wait cycles, then either MERR or T2..T6 / ILL
  task automatic build(input int d, input bit legal, input bit con);
    int n;
    exp_q.delete();
    md_q.delete();
    exp_q.push_back(b(19) | b(18) | b(17) | b(16) | b(3));
    md_q.push_back(-1);
    n = (d <= int'(TO)) ? d : int'(TO);
    for (int k = 1; k <= n; k++) begin
      exp_q.push_back(b(15) | b(14) | b(13) | b(12) | b(3));
      md_q.push_back((k == d) ? 1 : 0);
    end
    if (d <= int'(TO)) begin
      exp_q.push_back(b(11) | b(10) | b(3));
      md_q.push_back(-1);
      if (legal) begin
        exp_q.push_back(b(9) | b(8) | b(7) | b(3));
        exp_q.push_back(b(19) | b(6) | b(3));
        exp_q.push_back(b(5) | b(4) | b(16) | b(3));
        exp_q.push_back(b(15) | (con ? b(14) : 20'(0)) | b(2) | b(3));
        repeat (3) md_q.push_back(-1);
        md_q.push_back(-1);
      end else begin
        exp_q.push_back(b(3));
        exp_q.push_back(b(1) | b(3));
        repeat (2) md_q.push_back(-1);
      end
    end else begin
      exp_q.push_back(b(0) | b(3));
      md_q.push_back(-1);
    end
  endtask

  task automatic run_txn(input int txn, input int d, input bit legal, input bit con,
                         input bit hold, input logic [4:0] bad_op, input int stop_at);
    logic [4:0] op;
    op = legal ? 5'b10010 : bad_op;
    if (!legal && op == 5'b10010) op = 5'b10011;
    build(d, legal, con);
    @(negedge clk);
    opcode   = op;
    con_out  = con;
    mem_done = 1'($urandom);
    start    = 1'b1;
    chk($sformatf("txn%0d idle", txn), obs(), 20'(0));
    foreach (exp_q[i]) begin
      @(negedge clk);
      start    = hold ? 1'b1 : 1'($urandom);
      mem_done = (md_q[i] < 0) ? 1'($urandom) : 1'(md_q[i]);
      chk($sformatf("txn%0d cyc%0d", txn, i), obs(), exp_q[i]);
      if (i == stop_at) break;
    end
  endtask

  task automatic idle_gap(input int txn);
    @(negedge clk);
    start    = 1'b0;
    mem_done = 1'($urandom);
    chk($sformatf("txn%0d gap", txn), obs(), 20'(0));
  endtask

  initial begin
    start = 1'b1;
    #1 chk("reset_async", obs(), 20'(0));
    @(negedge clk);
    chk("reset_hold", obs(), 20'(0));
    start   = 1'b0;
    reset_n = 1'b1;
    idle_gap(0);

    run_txn(1, 1, 1'b1, 1'b1, 1'b0, 5'b0, -1);   // branch taken
    run_txn(2, 1, 1'b1, 1'b0, 1'b0, 5'b0, -1);   // branch not taken
    run_txn(3, 5, 1'b1, 1'b1, 1'b0, 5'b0, -1);   // memory wait of 5
    run_txn(4, 1000, 1'b1, 1'b1, 1'b0, 5'b0, -1); // timeout
    run_txn(5, 1, 1'b0, 1'b1, 1'b0, 5'b00011, -1); // illegal opcode
    idle_gap(5);
    run_txn(6, int'(TO), 1'b1, 1'b1, 1'b1, 5'b0, -1);     // mem_done on last allowed cycle
    run_txn(7, int'(TO) + 1, 1'b1, 1'b0, 1'b1, 5'b0, -1); // one cycle too late

    // reset during T4 (d=1: T0, T1, T2, T3, T4 at index 4)
    run_txn(8, 1, 1'b1, 1'b1, 1'b1, 5'b0, 4);
    #1 reset_n = 1'b0;
    #1 chk("reset_mid", obs(), 20'(0));
    @(negedge clk);
    chk("reset_mid_hold", obs(), 20'(0));
    start   = 1'b0;
    reset_n = 1'b1;
    run_txn(9, 1, 1'b1, 1'b1, 1'b0, 5'b0, -1);
    run_txn(10, 1000, 1'b1, 1'b0, 1'b0, 5'b0, -1);

    for (int t = 11; t < 81; t++) begin
      run_txn(t, int'($urandom_range(1, 20)), ($urandom % 4) != 0, 1'($urandom),
              1'($urandom), 5'($urandom), -1);
      if (($urandom % 3) == 0) idle_gap(t);
    end
    idle_gap(81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
